// File: rtl/ram_burst_reader.sv
// ram_burst_reader: sequences burst reads from a dual-port RAM read port and streams the words out on valid/ready
//
// Ports
//   clk, reset             single clock; asynchronous active-high reset
//   start, start_addr, len burst command (len = word count 0..2**W), accepted only when idle
//   abort                  stop issuing reads; words already requested still drain
//   busy, done, err        status: busy during a burst, done/err are 1-cycle pulses
//   ram_write_n            host write strobe of the shared RAM (low = host writes, read is lost)
//   ram_oe, ram_rd_addr    read request / address to the RAM
//   ram_rd_data            RAM read data, valid the cycle after an accepted request
//   m_data, m_valid, m_ready  output stream
//
// Build option: define RAM_RD_WRAP_EN to let bursts wrap past the top of the RAM;
// otherwise a command with start_addr+len > 2**W is rejected with err.
module ram_burst_reader #(
    parameter int B = 32,
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] start_addr,
    input  logic [W:0]   len,
    input  logic         abort,
    output logic         busy,
    output logic         done,
    output logic         err,
    input  logic         ram_write_n,
    output logic         ram_oe,
    output logic [W-1:0] ram_rd_addr,
    input  logic [B-1:0] ram_rd_data,
    output logic [B-1:0] m_data,
    output logic         m_valid,
    input  logic         m_ready
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t       state;
    logic [W:0]   remaining;
    logic [1:0]   cnt;
    logic         inflight;
    logic [B-1:0] tail;
    logic         push, pop, accept, range_ok;
    logic [1:0]   cnt_nxt;
`ifdef RAM_RD_WRAP_EN
    assign range_ok = 1'b1;
`else
    logic [W+1:0] end_addr;
    assign end_addr = {2'b00, start_addr} + {1'b0, len};
    assign range_ok = end_addr <= {2'b01, {W{1'b0}}};
`endif
    assign m_valid = cnt != 2'd0;
    assign pop     = m_valid & m_ready;
    assign push    = inflight;
    // Occupancy after this cycle's push/pop; a read issued now lands next cycle,
    // so issuing while this is below 2 can never overflow, yet sustains 1 word/cycle.
    assign cnt_nxt = cnt + {1'b0, push} - {1'b0, pop};
    // Kept combinational so abort stops issuing in the very cycle it is seen.
    assign ram_oe  = (state == RUN) && !abort && (remaining != '0) && (cnt_nxt < 2'd2);
    assign accept  = ram_oe & ram_write_n;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            ram_rd_addr <= '0;
            remaining   <= '0;
            inflight    <= 1'b0;
            cnt         <= 2'd0;
            m_data      <= '0;
            tail        <= '0;
        end else begin
            done     <= 1'b0;
            err      <= 1'b0;
            inflight <= accept;
            cnt      <= cnt_nxt;
            // m_data is the FIFO head register, tail the second slot
            if (push && (cnt == 2'd0 || (cnt == 2'd1 && pop)))
                m_data <= ram_rd_data;
            else if (pop && cnt == 2'd2)
                m_data <= tail;
            if (push && ((cnt == 2'd1 && !pop) || cnt == 2'd2))
                tail <= ram_rd_data;
            if (accept) begin
                ram_rd_addr <= ram_rd_addr + W'(1);
                remaining   <= remaining - (W+1)'(1);
            end
            case (state)
                IDLE: if (start) begin
                    if (abort || len == '0)
                        done <= 1'b1;
                    else if (!range_ok)
                        err <= 1'b1;
                    else begin
                        state       <= RUN;
                        busy        <= 1'b1;
                        ram_rd_addr <= start_addr;
                        remaining   <= len;
                    end
                end
                RUN: if (abort || (accept && remaining == (W+1)'(1)))
                    state <= DRAIN;
                DRAIN: if (cnt_nxt == 2'd0) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
